// File: rtl/mac_accumulator.sv
// Sequential multiply-accumulate stage feeding an external 4x4 multiplier and summing its products.
// Build option: define MAC_SATURATE_EN to clamp the accumulator at its maximum on carry instead of wrapping.
module mac_accumulator #(
    parameter int ACC_W     = 16,
    parameter int MUL_LAT   = 1,
    parameter int MAX_TERMS = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_last,
    output logic [3:0]       mul_a,
    output logic [3:0]       mul_b,
    input  logic [7:0]       mul_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       out_count,
    output logic             overflow
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] LAT_LAST = 3'(MUL_LAT - 1);
    localparam logic [7:0] MAX_CNT  = 8'(MAX_TERMS);

    logic [1:0]       state_r;
    logic [3:0]       mul_a_r;
    logic [3:0]       mul_b_r;
    logic             last_r;
    logic [2:0]       wait_cnt_r;
    logic [ACC_W-1:0] acc_r;
    logic [7:0]       count_r;
    logic             overflow_r;
    logic             out_valid_r;

    logic [ACC_W:0]   sum_s;
    logic [ACC_W-1:0] acc_add_s;
    logic [7:0]       count_inc_s;
    logic             in_ready_s;

    // Next accumulator value: one extra bit catches the carry out of the add.
    always_comb begin
        sum_s       = {1'b0, acc_r} + {{(ACC_W - 7){1'b0}}, mul_y};
        count_inc_s = count_r + 8'd1;
        in_ready_s  = (state_r == ST_IDLE);
`ifdef MAC_SATURATE_EN
        if (sum_s[ACC_W]) begin
            acc_add_s = {ACC_W{1'b1}};
        end else begin
            acc_add_s = sum_s[ACC_W-1:0];
        end
`else
        acc_add_s = sum_s[ACC_W-1:0];
`endif
    end

    // Control FSM with operand, accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            mul_a_r     <= 4'd0;
            mul_b_r     <= 4'd0;
            last_r      <= 1'b0;
            wait_cnt_r  <= 3'd0;
            acc_r       <= {ACC_W{1'b0}};
            count_r     <= 8'd0;
            overflow_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        mul_a_r    <= in_a;
                        mul_b_r    <= in_b;
                        last_r     <= in_last;
                        wait_cnt_r <= 3'd0;
                        state_r    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    wait_cnt_r <= wait_cnt_r + 3'd1;
                    if (wait_cnt_r == LAT_LAST) begin
                        acc_r   <= acc_add_s;
                        count_r <= count_inc_s;
                        if (sum_s[ACC_W]) begin
                            overflow_r <= 1'b1;
                        end
                        // MAX_TERMS forces a finish so out_count can never wrap.
                        if (last_r || (count_inc_s == MAX_CNT)) begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc_r       <= {ACC_W{1'b0}};
                        count_r     <= 8'd0;
                        overflow_r  <= 1'b0;
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_s;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;
    assign out_valid = out_valid_r;
    assign out_acc   = acc_r;
    assign out_count = count_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomized self-checking bench for mac_accumulator: two instances (wide/fast and narrow/slow)
// checked against a running-total model of each accumulation.
module tb_mac_accumulator;

`ifdef MAC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [3:0] in_a      [2];
    logic [3:0] in_b      [2];
    logic       in_last   [2];
    logic [3:0] mul_a     [2];
    logic [3:0] mul_b     [2];
    logic [7:0] mul_y     [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_count [2];
    logic       overflow  [2];
    logic [15:0] acc0;
    logic [7:0]  acc1;
    logic [31:0] acc_w [2];

    int accw [2] = '{16, 8};
    int lat  [2] = '{1, 3};
    int maxt [2] = '{255, 3};

    longint msum [2];
    int     mcnt [2];
    int     checks;
    int     errors;

    assign mul_y[0] = {4'd0, mul_a[0]} * {4'd0, mul_b[0]};
    assign mul_y[1] = {4'd0, mul_a[1]} * {4'd0, mul_b[1]};
    assign acc_w[0] = {16'd0, acc0};
    assign acc_w[1] = {24'd0, acc1};

    mac_accumulator #(.ACC_W(16), .MUL_LAT(1), .MAX_TERMS(255)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_last(in_last[0]),
        .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_y(mul_y[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_acc(acc0), .out_count(out_count[0]), .overflow(overflow[0])
    );

    mac_accumulator #(.ACC_W(8), .MUL_LAT(3), .MAX_TERMS(3)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_last(in_last[1]),
        .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_y(mul_y[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_acc(acc1), .out_count(out_count[1]), .overflow(overflow[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input int k);
        check_eq("rst_acc", acc_w[k], 0);
        check_eq("rst_count", out_count[k], 0);
        check_eq("rst_overflow", overflow[k], 0);
        check_eq("rst_out_valid", out_valid[k], 0);
        check_eq("rst_mul_a", mul_a[k], 0);
        check_eq("rst_mul_b", mul_b[k], 0);
        check_eq("rst_in_ready", in_ready[k], 1);
    endtask

    // Called and returns at a negedge; drives one pair and waits for the term to finish.
    task automatic do_term(input int k, input logic [3:0] a, input logic [3:0] b,
                           input logic last, output bit fin);
        int n;
        check_eq("in_ready_idle", in_ready[k], 1);
        in_valid[k] = 1'b1;
        in_a[k]     = a;
        in_b[k]     = b;
        in_last[k]  = last;
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        check_eq("mul_a", mul_a[k], longint'(a));
        check_eq("mul_b", mul_b[k], longint'(b));
        check_eq("in_ready_busy", in_ready[k], 0);
        msum[k] += longint'(a) * longint'(b);
        mcnt[k]++;
        fin = last || (mcnt[k] == maxt[k]);
        n = 0;
        while (!(fin ? out_valid[k] : in_ready[k]) && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check_eq(fin ? "latency_done" : "latency_term", n, lat[k]);
    endtask

    // Expects a result held for `hold` cycles while junk inputs are offered, then hands it off.
    task automatic collect(input int k, input int hold);
        longint lim, ea;
        bit     ovf;
        lim = longint'(1) << accw[k];
        ovf = (msum[k] >= lim);
        ea  = ovf ? (SAT ? lim - 1 : msum[k] % lim) : msum[k];
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_valid", out_valid[k], 1);
            check_eq("hold_in_ready", in_ready[k], 0);
            check_eq("hold_acc", acc_w[k], ea);
            in_valid[k] = 1'b1;
            in_a[k]     = 4'($urandom_range(0, 15));
            in_b[k]     = 4'($urandom_range(0, 15));
            in_last[k]  = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid[k] = 1'b0;
        check_eq("out_valid", out_valid[k], 1);
        check_eq("out_acc", acc_w[k], ea);
        check_eq("out_count", out_count[k], mcnt[k]);
        check_eq("overflow", overflow[k], longint'(ovf));
        out_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[k] = 1'b0;
        check_eq("post_valid", out_valid[k], 0);
        check_eq("post_in_ready", in_ready[k], 1);
        check_eq("post_acc", acc_w[k], 0);
        check_eq("post_overflow", overflow[k], 0);
        msum[k] = 0;
        mcnt[k] = 0;
    endtask

    task automatic run_acc(input int k, input int nterms);
        bit fin;
        for (int i = 0; i < nterms; i++) begin
            do_term(k, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    (i == nterms - 1), fin);
            if (fin) collect(k, int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        bit fin;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k] = 1'b0; in_a[k] = 4'd0; in_b[k] = 4'd0;
            in_last[k] = 1'b0; out_ready[k] = 1'b0;
            msum[k] = 0; mcnt[k] = 0;
        end
        repeat (2) @(negedge clk);
        check_idle_zero(0);
        check_idle_zero(1);
        rst_n = 1'b1;
        @(negedge clk);

        // 3*5 + 7*9 = 78, immediate handoff then a long stall
        do_term(0, 4'd3, 4'd5, 1'b0, fin);
        do_term(0, 4'd7, 4'd9, 1'b1, fin);
        collect(0, 0);
        do_term(0, 4'd3, 4'd5, 1'b0, fin);
        do_term(0, 4'd7, 4'd9, 1'b1, fin);
        collect(0, 10);

        // Reset while the second term is in the multiplier
        do_term(0, 4'd1, 4'd1, 1'b0, fin);
        in_valid[0] = 1'b1; in_a[0] = 4'd4; in_b[0] = 4'd4; in_last[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle_zero(0);
        @(negedge clk);
        rst_n = 1'b1;
        msum[0] = 0; mcnt[0] = 0;
        do_term(0, 4'd2, 4'd2, 1'b1, fin);
        collect(0, 1);

        // Narrow accumulator: 225+225 overflows 8 bits
        do_term(1, 4'd15, 4'd15, 1'b0, fin);
        do_term(1, 4'd15, 4'd15, 1'b1, fin);
        collect(1, 2);

        // MAX_TERMS=3 forces a finish; the fourth pair starts a fresh sum
        for (int i = 0; i < 4; i++) begin
            do_term(1, 4'd1, 4'd1, (i == 3), fin);
            if (fin) collect(1, 0);
        end

        // Three-cycle multiplier latency on a single term
        do_term(1, 4'd15, 4'd15, 1'b1, fin);
        collect(1, 0);

        for (int r = 0; r < 10; r++) run_acc(0, int'($urandom_range(1, 8)));
        for (int r = 0; r < 10; r++) run_acc(1, int'($urandom_range(1, 5)));
        // Long run crosses the 255-term forced finish
        run_acc(0, 260);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
